// File: rtl/operand_fetch.sv
// Operand fetch stage: 32x32 register file read into a one-entry valid/ready output register.
// Define WB_BYPASS_EN to forward same-edge writeback data into the captured operands.
module operand_fetch #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] instr,
    input  logic              wb_en,
    input  logic [4:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] gr1,
    output logic [DATA_W-1:0] gr2,
    output logic [DATA_W-1:0] i_datain
);

    localparam logic STATE_EMPTY = 1'b0;
    localparam logic STATE_FULL  = 1'b1;

    logic              state_q, state_d;
    logic [DATA_W-1:0] regs_q [32];
    logic [DATA_W-1:0] regs_d [32];
    logic [DATA_W-1:0] gr1_q, gr1_d;
    logic [DATA_W-1:0] gr2_q, gr2_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [DATA_W-1:0] rs_val, rt_val;
    logic [4:0]        rs, rt;
    logic              accept, consume;

    assign rs        = instr[25:21];
    assign rt        = instr[20:16];
    assign out_valid = (state_q == STATE_FULL);
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign consume   = out_valid && out_ready;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        regs_d = regs_q;
        if (wb_en && (wb_addr != 5'd0)) begin
            regs_d[wb_addr] = wb_data;
        end
    end

    // Register 0 is never written, so it reads back its reset value of zero.
    always_comb begin
        rs_val = regs_q[rs];
        rt_val = regs_q[rt];
`ifdef WB_BYPASS_EN
        if (wb_en && (wb_addr != 5'd0) && (wb_addr == rs)) begin
            rs_val = wb_data;
        end
        if (wb_en && (wb_addr != 5'd0) && (wb_addr == rt)) begin
            rt_val = wb_data;
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        gr1_d   = gr1_q;
        gr2_d   = gr2_q;
        instr_d = instr_q;
        if (accept) begin
            state_d = STATE_FULL;
            gr1_d   = rs_val;
            gr2_d   = rt_val;
            instr_d = instr;
        end else if (consume) begin
            state_d = STATE_EMPTY;
        end
    end

    // NOTE: the register file is cleared by the async reset too, so it is built from flops rather than RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= STATE_EMPTY;
            gr1_q   <= '0;
            gr2_q   <= '0;
            instr_q <= '0;
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            gr1_q   <= gr1_d;
            gr2_q   <= gr2_d;
            instr_q <= instr_d;
            regs_q  <= regs_d;
        end
    end

    assign gr1      = gr1_q;
    assign gr2      = gr2_q;
    assign i_datain = instr_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed self-checking bench for operand_fetch; expectations follow WB_BYPASS_EN when defined.
module tb_operand_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] gr1;
    logic [31:0] gr2;
    logic [31:0] i_datain;

    int n_checks = 0;
    int n_fail   = 0;

    operand_fetch #(.DATA_W(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .instr    (instr),
        .wb_en    (wb_en),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .gr1      (gr1),
        .gr2      (gr2),
        .i_datain (i_datain)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [4:0] addr, input logic [31:0] data);
        in_valid = 1'b0;
        wb_en    = 1'b1;
        wb_addr  = addr;
        wb_data  = data;
        tick();
        wb_en    = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; instr = '0; wb_en = 1'b0;
        wb_addr = '0; wb_data = '0; out_ready = 1'b0;
        #2;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        n_checks++; if ({gr1, gr2, i_datain} !== 96'h0) begin n_fail++; $display("FAIL reset_outputs: got %h %h %h expected zeros", gr1, gr2, i_datain); end
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        write_reg(5'd1, 32'hDDDD_DDDD);
        in_valid = 1'b1; instr = 32'h0001_1040; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_out_valid: got %b expected 1", out_valid); end
        n_checks++; if (gr1 !== 32'h0) begin n_fail++; $display("FAIL basic_gr1: got %h expected 00000000", gr1); end
        n_checks++; if (gr2 !== 32'hDDDD_DDDD) begin n_fail++; $display("FAIL basic_gr2: got %h expected dddddddd", gr2); end
        n_checks++; if (i_datain !== 32'h0001_1040) begin n_fail++; $display("FAIL basic_i_datain: got %h expected 00011040", i_datain); end
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (gr2 !== 32'hDDDD_DDDD || i_datain !== 32'h0001_1040) begin n_fail++; $display("FAIL drain_keep: got %h %h expected dddddddd 00011040", gr2, i_datain); end
    endtask

    task automatic test_reg_zero;
        write_reg(5'd0, 32'hFFFF_FFFF);
        in_valid = 1'b1; instr = 32'h0000_0000; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL r0_out_valid: got %b expected 1", out_valid); end
        n_checks++; if (gr1 !== 32'h0 || gr2 !== 32'h0) begin n_fail++; $display("FAIL r0_read: got %h %h expected 00000000 00000000", gr1, gr2); end
        tick();
    endtask

    task automatic test_hold;
        in_valid = 1'b1; instr = 32'h0001_1040; out_ready = 1'b0;
        tick();
        n_checks++; if (out_valid !== 1'b1 || gr2 !== 32'hDDDD_DDDD) begin n_fail++; $display("FAIL hold_load: got %b %h expected 1 dddddddd", out_valid, gr2); end
        // A competing instruction is offered while the output is stalled.
        instr = 32'h0021_1040;
        wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'h4040_4040;
        for (int c = 0; c < 3; c++) begin
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL hold_in_ready[%0d]: got %b expected 0", c, in_ready); end
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || gr1 !== 32'h0 || gr2 !== 32'hDDDD_DDDD || i_datain !== 32'h0001_1040) begin
                n_fail++;
                $display("FAIL hold_stable[%0d]: got %b %h %h %h expected 1 00000000 dddddddd 00011040", c, out_valid, gr1, gr2, i_datain);
            end
        end
        wb_en = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL hold_release: got %b expected 0", out_valid); end
        n_checks++; if (i_datain !== 32'h0001_1040) begin n_fail++; $display("FAIL hold_no_dup: got %h expected 00011040", i_datain); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] b2b_instr [4];
        logic [31:0] b2b_gr1 [4];
        logic [31:0] b2b_gr2 [4];
        b2b_instr = '{32'h0041_0000, 32'h0062_0001, 32'h0083_0002, 32'h00A4_0003};
        b2b_gr1   = '{32'h2222_2222, 32'h3333_3333, 32'h4444_4444, 32'h5555_5555};
        b2b_gr2   = '{32'h4040_4040, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
        write_reg(5'd2, 32'h2222_2222);
        write_reg(5'd3, 32'h3333_3333);
        write_reg(5'd4, 32'h4444_4444);
        write_reg(5'd5, 32'h5555_5555);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; instr = b2b_instr[k];
            n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready[%0d]: got %b expected 1", k, in_ready); end
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || i_datain !== b2b_instr[k] || gr1 !== b2b_gr1[k] || gr2 !== b2b_gr2[k]) begin
                n_fail++;
                $display("FAIL b2b[%0d]: got %b %h %h %h expected 1 %h %h %h", k, out_valid, i_datain, gr1, gr2, b2b_instr[k], b2b_gr1[k], b2b_gr2[k]);
            end
        end
        in_valid = 1'b0;
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got %b expected 0", out_valid); end
    endtask

    task automatic test_bypass;
        logic [31:0] exp_fwd;
`ifdef WB_BYPASS_EN
        exp_fwd = 32'h1234_5678;
`else
        exp_fwd = 32'hDDDD_DDDD;
`endif
        write_reg(5'd1, 32'hDDDD_DDDD);
        wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'h1234_5678;
        in_valid = 1'b1; instr = 32'h0021_1040; out_ready = 1'b1;
        tick();
        wb_en = 1'b0;
        n_checks++; if (gr1 !== exp_fwd || gr2 !== exp_fwd) begin n_fail++; $display("FAIL bypass_same_edge: got %h %h expected %h", gr1, gr2, exp_fwd); end
        tick();
        n_checks++; if (gr1 !== 32'h1234_5678 || gr2 !== 32'h1234_5678) begin n_fail++; $display("FAIL bypass_write_done: got %h %h expected 12345678", gr1, gr2); end
        // Register 0 must never forward, even with a same-edge write to it.
        wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hCAFE_F00D;
        instr = 32'h0000_0000;
        tick();
        wb_en = 1'b0; in_valid = 1'b0;
        n_checks++; if (gr1 !== 32'h0 || gr2 !== 32'h0) begin n_fail++; $display("FAIL bypass_r0: got %h %h expected 00000000", gr1, gr2); end
        tick();
    endtask

    task automatic test_reset_mid;
        in_valid = 1'b1; instr = 32'h0021_1040; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1 || gr1 !== 32'h1234_5678) begin n_fail++; $display("FAIL rmid_full: got %b %h expected 1 12345678", out_valid, gr1); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_valid: got %b %b expected 0 1", out_valid, in_ready); end
        n_checks++; if ({gr1, gr2, i_datain} !== 96'h0) begin n_fail++; $display("FAIL rmid_clear: got %h %h %h expected zeros", gr1, gr2, i_datain); end
        // Write and accept attempts while held in reset must be ignored.
        wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'h7777_7777;
        in_valid = 1'b1; instr = 32'h0021_1040; out_ready = 1'b1;
        tick();
        n_checks++; if (out_valid !== 1'b0 || gr1 !== 32'h0) begin n_fail++; $display("FAIL rmid_in_reset: got %b %h expected 0 00000000", out_valid, gr1); end
        wb_en = 1'b0;
        rst_n = 1'b1;
        tick();
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1 || i_datain !== 32'h0021_1040) begin n_fail++; $display("FAIL rmid_first_accept: got %b %h expected 1 00211040", out_valid, i_datain); end
        n_checks++; if (gr1 !== 32'h0 || gr2 !== 32'h0) begin n_fail++; $display("FAIL rmid_r1_cleared: got %h %h expected 00000000", gr1, gr2); end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_reg_zero();
        test_hold();
        test_back_to_back();
        test_bypass();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
